// File: rtl/mem_word_ctrl.sv
// Word access controller: splits one 16-bit read or write into two byte accesses
// at A and A+1 on an 8-bit registered-read memory port.
module mem_word_ctrl #(
  parameter int unsigned BIG_ENDIAN = 1
) (
  input  logic        ctrl_clk,
  input  logic        ctrl_rst,
  input  logic        ctrl_req,
  input  logic        ctrl_we,
  input  logic [15:0] ctrl_addr,
  input  logic [15:0] ctrl_wdata,
  output logic [15:0] ctrl_rdata,
  output logic        ctrl_busy,
  output logic        ctrl_done,
  output logic [15:0] ctrl_mem_addr,
  output logic [7:0]  ctrl_mem_wdata,
  output logic        ctrl_mem_rd_en,
  output logic        ctrl_mem_wr_en,
  input  logic [7:0]  ctrl_mem_rdata
);

  typedef enum logic [2:0] {
    StIdle,
    StRd0,
    StRd1,
    StRd2,
    StWr0,
    StWr1,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [7:0]  byte_q;
  logic [15:0] rdata_q;
  logic [15:0] addr_inc;

  assign addr_inc = addr_q + 16'd1;

  always_ff @(posedge ctrl_clk or posedge ctrl_rst) begin
    if (ctrl_rst) begin
      state_q <= StIdle;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      byte_q  <= 8'h00;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && ctrl_req) begin
        addr_q  <= ctrl_addr;
        wdata_q <= ctrl_wdata;
      end
      // Memory returns byte A during RD1 and byte A+1 during RD2.
      if (state_q == StRd1) begin
        byte_q <= ctrl_mem_rdata;
      end
      if (state_q == StRd2) begin
        rdata_q <= (BIG_ENDIAN != 0) ? {byte_q, ctrl_mem_rdata} : {ctrl_mem_rdata, byte_q};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (ctrl_req) begin
          state_d = ctrl_we ? StWr0 : StRd0;
        end
      end
      StRd0:   state_d = StRd1;
      StRd1:   state_d = StRd2;
      StRd2:   state_d = StDone;
      StWr0:   state_d = StWr1;
      StWr1:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Memory-side outputs decode registered state only; nothing depends on ctrl_req.
  always_comb begin
    ctrl_mem_addr  = 16'h0000;
    ctrl_mem_wdata = 8'h00;
    ctrl_mem_rd_en = 1'b0;
    ctrl_mem_wr_en = 1'b0;
    unique case (state_q)
      StRd0: begin
        ctrl_mem_addr  = addr_q;
        ctrl_mem_rd_en = 1'b1;
      end
      StRd1: begin
        ctrl_mem_addr  = addr_inc;
        ctrl_mem_rd_en = 1'b1;
      end
      StWr0: begin
        ctrl_mem_addr  = addr_q;
        ctrl_mem_wdata = (BIG_ENDIAN != 0) ? wdata_q[15:8] : wdata_q[7:0];
        ctrl_mem_wr_en = 1'b1;
      end
      StWr1: begin
        ctrl_mem_addr  = addr_inc;
        ctrl_mem_wdata = (BIG_ENDIAN != 0) ? wdata_q[7:0] : wdata_q[15:8];
        ctrl_mem_wr_en = 1'b1;
      end
      default: begin
        ctrl_mem_addr  = 16'h0000;
        ctrl_mem_wdata = 8'h00;
      end
    endcase
  end

  assign ctrl_rdata = rdata_q;
  assign ctrl_busy  = (state_q != StIdle);
  assign ctrl_done  = (state_q == StDone);

endmodule

// File: tb/tb_mem_word_ctrl.sv
// Bench for mem_word_ctrl: big- and little-endian instances share stimulus, each
// with its own byte memory, checked against a word-level reference memory.
module tb_mem_word_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [15:0] wdata = 16'h0000;

  logic [15:0] be_rdata, le_rdata, be_maddr, le_maddr;
  logic        be_busy, le_busy, be_done, le_done;
  logic [7:0]  be_mwdata, le_mwdata, be_mrd, le_mrd;
  logic        be_rd, le_rd, be_wr, le_wr;

  logic [7:0] mem_be [0:65535];
  logic [7:0] mem_le [0:65535];
  logic [7:0] ref_be [0:65535];
  logic [7:0] ref_le [0:65535];

  int n_cmp = 0;
  int n_bad = 0;
  logic be_done_prev = 1'b0;
  logic le_done_prev = 1'b0;

  always #5 clk = ~clk;

  mem_word_ctrl #(.BIG_ENDIAN(1)) u_be (
    .ctrl_clk(clk), .ctrl_rst(rst), .ctrl_req(req), .ctrl_we(we), .ctrl_addr(addr),
    .ctrl_wdata(wdata), .ctrl_rdata(be_rdata), .ctrl_busy(be_busy), .ctrl_done(be_done),
    .ctrl_mem_addr(be_maddr), .ctrl_mem_wdata(be_mwdata), .ctrl_mem_rd_en(be_rd),
    .ctrl_mem_wr_en(be_wr), .ctrl_mem_rdata(be_mrd)
  );

  mem_word_ctrl #(.BIG_ENDIAN(0)) u_le (
    .ctrl_clk(clk), .ctrl_rst(rst), .ctrl_req(req), .ctrl_we(we), .ctrl_addr(addr),
    .ctrl_wdata(wdata), .ctrl_rdata(le_rdata), .ctrl_busy(le_busy), .ctrl_done(le_done),
    .ctrl_mem_addr(le_maddr), .ctrl_mem_wdata(le_mwdata), .ctrl_mem_rd_en(le_rd),
    .ctrl_mem_wr_en(le_wr), .ctrl_mem_rdata(le_mrd)
  );

  // Byte memories: registered read, write on the edge, cleared and preloaded in reset.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 65536; i++) begin
        mem_be[i] <= 8'h00;
        mem_le[i] <= 8'h00;
      end
      mem_be[6] <= 8'hB3;
      mem_be[7] <= 8'hD8;
      mem_le[6] <= 8'hB3;
      mem_le[7] <= 8'hD8;
    end else begin
      if (be_wr) mem_be[be_maddr] <= be_mwdata;
      if (be_rd) be_mrd <= mem_be[be_maddr];
      if (le_wr) mem_le[le_maddr] <= le_mwdata;
      if (le_rd) le_mrd <= mem_le[le_maddr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_read(input bit big, input logic [15:0] a);
    logic [15:0] b;
    b = a + 16'd1;
    if (big) return {ref_be[a], ref_be[b]};
    return {ref_le[b], ref_le[a]};
  endfunction

  task automatic ref_write(input logic [15:0] a, input logic [15:0] d);
    logic [15:0] b;
    b = a + 16'd1;
    ref_be[a] = d[15:8];
    ref_be[b] = d[7:0];
    ref_le[a] = d[7:0];
    ref_le[b] = d[15:8];
  endtask

  // Invariants checked every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      check("en_excl_be", 32'(be_rd & be_wr), 32'd0);
      check("en_excl_le", 32'(le_rd & le_wr), 32'd0);
      check("done_width_be", 32'(be_done_prev & be_done), 32'd0);
      check("done_width_le", 32'(le_done_prev & le_done), 32'd0);
      be_done_prev = be_done;
      le_done_prev = le_done;
    end else begin
      be_done_prev = 1'b0;
      le_done_prev = 1'b0;
    end
  end

  // One word operation; k counts edges after acceptance when done is sampled.
  task automatic do_op(input bit w, input logic [15:0] a, input logic [15:0] d,
                       input bit intrude);
    logic [15:0] be_before, le_before, a1;
    int k_be, k_le;
    k_be = 99;
    k_le = 99;
    a1 = a + 16'd1;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    be_before = be_rdata;
    le_before = le_rdata;
    if (w) ref_write(a, d);
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; we = 1'b0; addr = 16'h0000; wdata = 16'h0000;
    check("busy_be", 32'(be_busy), 32'd1);
    check("busy_le", 32'(le_busy), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (intrude && k == 1) begin
        req = 1'b1; we = 1'b1; addr = 16'h0200; wdata = 16'hFFFF;
      end else begin
        req = 1'b0; we = 1'b0; addr = 16'h0000; wdata = 16'h0000;
      end
      if (w && k == 1) begin
        check("wr_byte0_be", 32'(mem_be[a]), 32'(ref_be[a]));
        check("wr_byte0_le", 32'(mem_le[a]), 32'(ref_le[a]));
      end
      if (w && k == 2) begin
        check("wr_byte1_be", 32'(mem_be[a1]), 32'(ref_be[a1]));
        check("wr_byte1_le", 32'(mem_le[a1]), 32'(ref_le[a1]));
      end
      if (be_done && k_be == 99) k_be = k;
      if (le_done && k_le == 99) k_le = k;
      if (k_be != 99 && k_le != 99) break;
    end
    check("done_lat_be", 32'(k_be), w ? 32'd2 : 32'd3);
    check("done_lat_le", 32'(k_le), w ? 32'd2 : 32'd3);
    if (w) begin
      check("rdata_hold_be", 32'(be_rdata), 32'(be_before));
      check("rdata_hold_le", 32'(le_rdata), 32'(le_before));
    end else begin
      check("rdata_be", 32'(be_rdata), 32'(ref_read(1'b1, a)));
      check("rdata_le", 32'(le_rdata), 32'(ref_read(1'b0, a)));
    end
  endtask

  initial begin
    int cnt, d1, d2;
    logic [15:0] a;
    for (int i = 0; i < 65536; i++) begin
      ref_be[i] = 8'h00;
      ref_le[i] = 8'h00;
    end
    ref_be[6] = 8'hB3; ref_be[7] = 8'hD8;
    ref_le[6] = 8'hB3; ref_le[7] = 8'hD8;

    // Reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_be", {be_rdata, be_busy, be_done, be_mwdata, be_rd, be_wr}, 32'd0);
    check("idle_le", {le_rdata, le_busy, le_done, le_mwdata, le_rd, le_wr}, 32'd0);
    check("idle_addr", {be_maddr, le_maddr}, 32'd0);

    // Reads of the preloaded word in both byte orders
    do_op(1'b0, 16'h0006, 16'h0000, 1'b0);
    check("rd6_be_const", 32'(be_rdata), 32'h0000B3D8);
    check("rd6_le_const", 32'(le_rdata), 32'h0000D8B3);

    // Asynchronous reset during RD1
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 16'h0006;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; addr = 16'h0000;
    @(posedge clk);
    #2;
    check("rd1_rden", 32'(be_rd), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_en", {be_rd, be_wr, le_rd, le_wr, be_busy, le_busy}, 32'd0);
    check("arst_rdata", {be_rdata, le_rdata}, 32'd0);
    check("arst_addr", {be_maddr, le_maddr}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Write, read back, wrap-around
    do_op(1'b1, 16'h0100, 16'hA55A, 1'b0);
    check("wr100_byte", 32'(mem_be[16'h0100]), 32'h000000A5);
    do_op(1'b0, 16'h0100, 16'h0000, 1'b0);
    check("rd100_be_const", 32'(be_rdata), 32'h0000A55A);
    do_op(1'b1, 16'hFFFF, 16'h1234, 1'b0);
    check("wrap_bytes", {mem_be[16'hFFFF], mem_be[16'h0000]}, 32'h00001234);
    do_op(1'b0, 16'hFFFF, 16'h0000, 1'b0);
    check("rdFFFF_be_const", 32'(be_rdata), 32'h00001234);

    // Request during RD1 is ignored
    do_op(1'b0, 16'h0006, 16'h0000, 1'b1);
    check("ignored_be", {mem_be[16'h0200], mem_be[16'h0201]}, 32'd0);
    check("ignored_le", {mem_le[16'h0200], mem_le[16'h0201]}, 32'd0);

    // Request held for 10 edges: two reads, done pulses 5 cycles apart
    cnt = 0; d1 = -1; d2 = -1;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 16'h0006;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 9) begin
        req = 1'b0; addr = 16'h0000;
      end
      if (be_done) begin
        cnt++;
        if (d1 < 0) d1 = i; else if (d2 < 0) d2 = i;
      end
    end
    check("held_count", 32'(cnt), 32'd2);
    check("held_first", 32'(d1), 32'd3);
    check("held_spacing", 32'(d2 - d1), 32'd5);
    check("held_rdata", 32'(be_rdata), 32'h0000B3D8);

    // Randomized traffic over a small window so reads see earlier writes
    for (int n = 0; n < 40; n++) begin
      a = 16'h0300 + 16'($urandom_range(0, 15));
      do_op(1'($urandom_range(0, 1)), a, 16'($urandom), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
